// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the up/down counter sequencing controller.
//   state_e   : controller FSM states
//   DIR_UP    : count direction toward a larger target
//   DIR_DOWN  : count direction toward a smaller target
package updown_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_seq_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
// The priority pointer register lives in the parent.
//   req_i          : request lines, bit k = requester k
//   prio_i         : requester that wins when both request
//   grant_o        : index of the granted requester
//   grant_valid_o  : at least one request is present
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    always_comb begin
        grant_valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = prio_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/updown_seq_ctrl.sv
// Scheduler for a shared up/down counter. Two requesters hand in targets
// over valid/ready; the granted one owns the counter, which steps by one per
// cycle toward its target, then receives a single-cycle done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; ready offered to the arbitration winner
// RUN   | counter stepping toward target_q, one step per clock
// DONE  | single cycle, done pulse to owner, round-robin pointer flips
//
// Ports:
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   req_valid_i    : per-requester valid
//   req_target0_i  : target from requester 0
//   req_target1_i  : target from requester 1
//   req_ready_o    : per-requester ready (only in IDLE, only to the winner)
//   abort_i        : cancel the operation in RUN, no done pulse
//   done_o         : completion pulse to the owning requester
//   busy_o         : high in RUN and DONE
//   owner_o        : currently or last granted requester
//   dir_o          : 1 = counting up, 0 = counting down
//   step_o         : count_o changes on the next edge
//   count_o        : counter value
module updown_seq_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    input  logic [WIDTH-1:0] req_target0_i,
    input  logic [WIDTH-1:0] req_target1_i,
    output logic [1:0]       req_ready_o,
    input  logic             abort_i,
    output logic [1:0]       done_o,
    output logic             busy_o,
    output logic             owner_o,
    output logic             dir_o,
    output logic             step_o,
    output logic [WIDTH-1:0] count_o
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] sel_target;
    logic             owner_q;
    logic             dir_q;
    logic             prio_q;
    logic             grant;
    logic             grant_valid;

    rr_arb2 u_arb (
        .req_i         (req_valid_i),
        .prio_i        (prio_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    assign sel_target = grant ? req_target1_i : req_target0_i;
    assign count_next = (dir_q == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            owner_q  <= 1'b0;
            dir_q    <= DIR_UP;
            prio_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // grant_valid implies valid & ready on the winner: handshake
                    if (grant_valid) begin
                        target_q <= sel_target;
                        owner_q  <= grant;
                        dir_q    <= (sel_target > count_q) ? DIR_UP : DIR_DOWN;
                        state_q  <= (sel_target == count_q) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // abort wins over the step, even on the final one
                    if (abort_i) begin
                        prio_q  <= ~owner_q;
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_next;
                        if (count_next == target_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    prio_q  <= ~owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is gated by reset so a held reset never offers a handshake.
    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == IDLE && grant_valid && !rst_i) begin
            req_ready_o = grant ? 2'b10 : 2'b01;
        end
    end

    assign done_o  = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy_o  = (state_q == RUN) || (state_q == DONE);
    assign step_o  = (state_q == RUN) && !abort_i;
    assign owner_o = owner_q;
    assign dir_o   = dir_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
module tb_updown_seq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] req_valid_i;
    logic [3:0] req_target0_i;
    logic [3:0] req_target1_i;
    logic [1:0] req_ready_o;
    logic       abort_i;
    logic [1:0] done_o;
    logic       busy_o;
    logic       owner_o;
    logic       dir_o;
    logic       step_o;
    logic [3:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int model_count = 0;

    updown_seq_ctrl #(.WIDTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_target0_i (req_target0_i),
        .req_target1_i (req_target1_i),
        .req_ready_o   (req_ready_o),
        .abort_i       (abort_i),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .owner_o       (owner_o),
        .dir_o         (dir_o),
        .step_o        (step_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check("rst_count", int'(count_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ready", int'(req_ready_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_owner", int'(owner_o), 0);
        check("rst_dir", int'(dir_o), 1);
        check("rst_step", int'(step_o), 0);
        tick();
        rst_i = 1'b0;
        model_count = 0;
    endtask

    // Present valid_mask; expect exp_owner to win and walk n_steps to exp_target.
    // Targets are set by the caller.
    task automatic do_op(input logic [1:0] valid_mask, input int exp_owner,
                         input int exp_target, input int n_steps, input int exp_dir);
        req_valid_i = valid_mask;
        #1;
        check("ready_grant", int'(req_ready_o), 1 << exp_owner);
        tick();
        req_valid_i = valid_mask & ~(2'b01 << exp_owner);
        #1;
        check("owner", int'(owner_o), exp_owner);
        check("dir", int'(dir_o), exp_dir);
        check("busy_after_hs", int'(busy_o), 1);
        check("ready_busy", int'(req_ready_o), 0);
        for (int i = 0; i < n_steps; i++) begin
            check("step_run", int'(step_o), 1);
            tick();
            model_count = (exp_dir == 1) ? model_count + 1 : model_count - 1;
            check("count_step", int'(count_o), model_count);
        end
        check("done_pulse", int'(done_o), 1 << exp_owner);
        check("busy_done", int'(busy_o), 1);
        check("step_done", int'(step_o), 0);
        tick();
        check("done_clear", int'(done_o), 0);
        check("busy_idle", int'(busy_o), 0);
        check("count_final", int'(count_o), exp_target);
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 2'b00;
        req_target0_i = 4'd0;
        req_target1_i = 4'd0;
        abort_i = 1'b0;
        tick();
        do_reset();

        // basic up, down, zero-step
        req_target0_i = 4'd5;
        do_op(2'b01, 0, 5, 5, 1);
        req_target1_i = 4'd2;
        do_op(2'b10, 1, 2, 3, 0);
        do_op(2'b10, 1, 2, 0, 0);

        // both valid: round-robin order
        do_reset();
        req_target0_i = 4'd3;
        req_target1_i = 4'd1;
        do_op(2'b11, 0, 3, 3, 1);
        do_op(2'b10, 1, 1, 2, 0);
        do_op(2'b11, 0, 3, 2, 1);
        do_op(2'b10, 1, 1, 2, 0);

        // full-range boundaries
        do_reset();
        req_target0_i = 4'd15;
        do_op(2'b01, 0, 15, 15, 1);
        req_target0_i = 4'd0;
        do_op(2'b01, 0, 0, 15, 0);

        // abort at count 3 toward 9 (requester 1 owns; pointer was 1)
        req_target0_i = 4'd3;
        do_op(2'b01, 0, 3, 3, 1);
        req_target1_i = 4'd9;
        req_valid_i = 2'b10;
        #1;
        check("abort_ready", int'(req_ready_o), 2);
        tick();
        req_valid_i = 2'b00;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_count", int'(count_o), 3);
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        tick();
        check("abort_done_later", int'(done_o), 0);

        // pointer flipped to 0 by abort; abort on the final step toward 4
        req_target0_i = 4'd4;
        req_target1_i = 4'd7;
        req_valid_i = 2'b11;
        #1;
        check("abort_ptr_grant", int'(req_ready_o), 1);
        tick();
        req_valid_i = 2'b00;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_last_count", int'(count_o), 3);
        check("abort_last_busy", int'(busy_o), 0);
        check("abort_last_done", int'(done_o), 0);
        tick();
        check("abort_last_done2", int'(done_o), 0);

        // async reset mid-RUN at count 6 (pointer now 1, requester 1 alone)
        req_target1_i = 4'd9;
        req_valid_i = 2'b10;
        tick();
        req_valid_i = 2'b00;
        tick();
        tick();
        tick();
        check("pre_rst_count", int'(count_o), 6);
        #2;
        req_valid_i = 2'b01;
        rst_i = 1'b1;
        #1;
        check("arst_count", int'(count_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_done", int'(done_o), 0);
        check("arst_ready", int'(req_ready_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        req_valid_i = 2'b00;
        model_count = 0;
        req_target0_i = 4'd2;
        do_op(2'b01, 0, 2, 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
